ras_predictor: RTL



---
 rtl/ras_predictor_pkg.sv | 7 +
 rtl/ras_storage.sv | 41 ++++
 rtl/ras_predictor.sv | 102 ++++++++++
 3 files changed

// File: rtl/ras_predictor_pkg.sv
// Configuration constants shared by the return-address stack and its storage array.
package ras_predictor_pkg;

    localparam int unsigned XLEN_DEFAULT      = 64;
    localparam int unsigned RAS_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/ras_storage.sv
// Circular register array for the return-address stack: one synchronous write port,
// one asynchronous read port.
module ras_storage
    import ras_predictor_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_predictor.sv
// Speculative return-address stack: pops in Fetch, pushes calls from Execute and repairs
// the top pointer when speculative or late pops are flushed or turn out wrong.
module ras_predictor
    import ras_predictor_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            StallE,
    input  logic            StallM,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            FlushM,
    input  logic            BPReturnF,
    input  logic            ReturnD,
    input  logic            BPReturnWrongD,
    input  logic            CallE,
    input  logic [XLEN-1:0] PCLinkE,
    output logic [XLEN-1:0] RASPCF
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned SumW = PtrW + 2;

    logic            spec_pop_f;
    logic            late_pop_d;
    logic            undo_d;
    logic            undo_e;
    logic            push_e;
    logic            popped_d_q, popped_d_d;
    logic            popped_e_q, popped_e_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] restored_ptr;
    logic [PtrW-1:0] push_addr;
    logic [SumW-1:0] restored_sum;
    logic [SumW-1:0] next_sum;
    logic [1:0]      unused_sum_msbs;
    logic [XLEN-1:0] top_entry;

    always_comb begin
        spec_pop_f = BPReturnF & ~StallD & ~FlushD;
        late_pop_d = ReturnD & BPReturnWrongD & ~popped_d_q & ~StallE & ~FlushE;
        undo_d     = popped_d_q & (FlushE | (BPReturnWrongD & ~StallE));
        undo_e     = popped_e_q & FlushM;
        push_e     = CallE & ~StallM & ~FlushM;
    end

    // Undos land first, so the push goes just above the restored top; pops then follow.
    always_comb begin
        restored_sum    = {2'b00, ptr_q} + SumW'(undo_d) + SumW'(undo_e);
        next_sum        = restored_sum + SumW'(push_e) - SumW'(spec_pop_f) - SumW'(late_pop_d);
        restored_ptr    = restored_sum[PtrW-1:0];
        push_addr       = restored_ptr + PtrW'(1);
        ptr_d           = next_sum[PtrW-1:0];
        unused_sum_msbs = next_sum[SumW-1:PtrW] ^ restored_sum[SumW-1:PtrW];
    end

    // Enable-gated clear, matching the shared flopenrc behaviour.
    always_comb begin
        popped_d_d = popped_d_q;
        if (!StallD) begin
            popped_d_d = FlushD ? 1'b0 : spec_pop_f;
        end
        popped_e_d = popped_e_q;
        if (!StallE) begin
            popped_e_d = FlushE ? 1'b0 : ((popped_d_q & ~BPReturnWrongD) | late_pop_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            popped_d_q <= 1'b0;
            popped_e_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            popped_d_q <= popped_d_d;
            popped_e_q <= popped_e_d;
        end
    end

    ras_storage #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH),
        .AW    (PtrW)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push_e),
        .waddr_i (push_addr),
        .wdata_i (PCLinkE),
        .raddr_i (ptr_q),
        .rdata_o (top_entry)
    );

    // Forward the pushing call so a return right behind it sees the new address.
    assign RASPCF = push_e ? PCLinkE : top_entry;

endmodule
